mult_sched: RTL and testbench

- Round-robin scheduler sharing one sequential `multiplier` instance between NREQ requesters.
- Accepts operand pairs over per-requester valid/ready handshakes and drives the multiplier's `en`/operand inputs.
- Waits a fixed MUL_LAT cycles, captures `product`, and returns it with the requester id on a single result port with valid/ready.
- Sits between the datapath clients and the multiplier. The multiplier is instantiated beside it, not inside it.

---
 rtl/mult_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 36 +++
 rtl/mult_sched.sv | 138 +++++++++++++
 tb/tb_mult_sched.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared defaults and FSM state encoding for the multiplier scheduler.
package mult_pkg;

    localparam int M_DEF = 26;
    localparam int N_DEF = 14;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr_i, with wrap.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int ID_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [ID_W-1:0] ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [ID_W-1:0] idx_o,
    output logic            any_o
);

    logic [ID_W:0] pos;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        pos     = '0;
        for (int k = 0; k < NREQ; k++) begin
            // One extra bit so ptr+k never overflows before the wrap subtraction.
            pos = {1'b0, ptr_i} + (ID_W+1)'(k);
            if (pos >= (ID_W+1)'(NREQ)) begin
                pos = pos - (ID_W+1)'(NREQ);
            end
            if (!any_o && req_i[pos[ID_W-1:0]]) begin
                any_o = 1'b1;
                idx_o = pos[ID_W-1:0];
            end
        end
        if (any_o) begin
            grant_o[idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/mult_sched.sv
// Round-robin scheduler that time-shares one external sequential multiplier between NREQ clients.
module mult_sched
    import mult_pkg::*;
#(
    parameter int M       = M_DEF,
    parameter int N       = N_DEF,
    parameter int NREQ    = 4,
    parameter int MUL_LAT = 16,
    localparam int ID_W   = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*M-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    output logic              mul_en,
    output logic [M-1:0]      mul_a,
    output logic [N-1:0]      mul_b,
    input  logic [M+N-1:0]    mul_product,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ID_W-1:0]   res_id,
    output logic [M+N-1:0]    res_product,
    output logic              busy
);

    localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic             mul_en_q, mul_en_d;
    logic [M-1:0]     mul_a_q, mul_a_d;
    logic [N-1:0]     mul_b_q, mul_b_d;
    logic             res_valid_q, res_valid_d;
    logic [ID_W-1:0]  res_id_q, res_id_d;
    logic [M+N-1:0]   res_prod_q, res_prod_d;
    logic             busy_q, busy_d;

    logic [NREQ-1:0]  grant;
    logic [ID_W-1:0]  grant_idx;
    logic             grant_any;

    rr_arbiter #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_arb (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (grant),
        .idx_o   (grant_idx),
        .any_o   (grant_any)
    );

    // Valid/ready: a transfer happens on a rising edge where both are high; ready never waits on valid
    // falling, and a client must hold valid plus operands until it sees the transfer.
    assign req_ready = (state_q == ST_IDLE && !rst) ? grant : '0;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        mul_en_d    = mul_en_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        res_valid_d = res_valid_q;
        res_id_d    = res_id_q;
        res_prod_d  = res_prod_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_any && |(req_valid & req_ready)) begin
                    mul_a_d  = req_a[int'(grant_idx)*M +: M];
                    mul_b_d  = req_b[int'(grant_idx)*N +: N];
                    res_id_d = grant_idx;
                    mul_en_d = 1'b1;
                    cnt_d    = '0;
                    ptr_d    = (grant_idx == ID_W'(NREQ-1)) ? '0 : grant_idx + ID_W'(1);
                    state_d  = ST_BUSY;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(MUL_LAT-1)) begin
                    res_prod_d  = mul_product;
                    res_valid_d = 1'b1;
                    mul_en_d    = 1'b0;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            ptr_q       <= '0;
            mul_en_q    <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_prod_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            mul_en_q    <= mul_en_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            res_prod_q  <= res_prod_d;
            busy_q      <= busy_d;
        end
    end

    assign mul_en      = mul_en_q;
    assign mul_a       = mul_a_q;
    assign mul_b       = mul_b_q;
    assign res_valid   = res_valid_q;
    assign res_id      = res_id_q;
    assign res_product = res_prod_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_mult_sched.sv
// Bench for mult_sched: stub multiplier, event monitor, directed plus random steps vs. an order/product model.
module tb_mult_sched;

    localparam int M       = 26;
    localparam int N       = 14;
    localparam int NREQ    = 4;
    localparam int MUL_LAT = 16;
    localparam int ID_W    = $clog2(NREQ);
    localparam int RW      = ID_W + M + N;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*M-1:0] req_a;
    logic [NREQ*N-1:0] req_b;
    logic              mul_en;
    logic [M-1:0]      mul_a;
    logic [N-1:0]      mul_b;
    logic [M+N-1:0]    mul_product;
    logic              res_valid;
    logic              res_ready;
    logic [ID_W-1:0]   res_id;
    logic [M+N-1:0]    res_product;
    logic              busy;

    always #5 clk = ~clk;

    mult_sched #(
        .M       (M),
        .N       (N),
        .NREQ    (NREQ),
        .MUL_LAT (MUL_LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .mul_en      (mul_en),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_product (mul_product),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_id      (res_id),
        .res_product (res_product),
        .busy        (busy)
    );

    // Stub multiplier: the true product appears only during the MUL_LAT-th cycle of continuous en.
    int stub_cnt;
    always @(posedge clk or posedge rst) begin
        if (rst)         stub_cnt <= 0;
        else if (mul_en) stub_cnt <= stub_cnt + 1;
        else             stub_cnt <= 0;
    end
    assign mul_product = (mul_en && stub_cnt >= MUL_LAT-1)
                       ? ({{N{1'b0}}, mul_a} * {{M{1'b0}}, mul_b})
                       : ({(M+N){1'b1}} ^ {mul_a, mul_b});

    // Monitor: timestamps transfers at each rising edge using pre-edge values.
    int cyc = 0;
    int en_cyc = 0;
    int rdy_cyc = 0;
    int onehot_bad = 0;
    int acc_id_q[$];
    int acc_cyc_q[$];
    int rise_cyc_q[$];
    logic [RW-1:0] got_q[$];
    logic rv_prev = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst) begin
            if (mul_en) en_cyc <= en_cyc + 1;
            if (|req_ready) rdy_cyc <= rdy_cyc + 1;
            if (!$onehot0(req_ready)) onehot_bad <= onehot_bad + 1;
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    acc_id_q.push_back(i);
                    acc_cyc_q.push_back(cyc);
                end
            end
            if (res_valid && !rv_prev) rise_cyc_q.push_back(cyc);
            if (res_valid && res_ready) got_q.push_back({res_id, res_product});
            rv_prev <= res_valid;
        end else begin
            rv_prev <= 1'b0;
        end
    end

    int tests = 0;
    int fails = 0;
    int m_ptr = 0;
    int acc_seen = 0;
    int got_seen = 0;
    logic [RW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance one cycle and withdraw valid from every requester that has just been accepted.
    task automatic step();
        tick();
        while (acc_seen < acc_id_q.size()) begin
            req_valid[acc_id_q[acc_seen]] = 1'b0;
            acc_seen++;
        end
    endtask

    task automatic set_req(input int i, input logic [M-1:0] a, input logic [N-1:0] b);
        req_a[i*M +: M] = a;
        req_b[i*N +: N] = b;
        req_valid[i]    = 1'b1;
    endtask

    function automatic int pick(input logic [NREQ-1:0] mask, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (mask[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    // Reference: serve the requests in mask one at a time in rotating order from the model pointer.
    task automatic issue(input logic [NREQ-1:0] mask);
        logic [NREQ-1:0] m;
        logic [M+N-1:0]  p;
        int g;
        m = mask;
        while (m != '0) begin
            g = pick(m, m_ptr);
            p = (M+N)'(req_a[g*M +: M]) * (M+N)'(req_b[g*N +: N]);
            exp_q.push_back({ID_W'(g), p});
            m_ptr = (g + 1) % NREQ;
            m[g]  = 1'b0;
        end
    endtask

    task automatic run(input int n, input bit rand_bp, input int budget);
        int target;
        target = got_q.size() + n;
        for (int k = 0; k < budget; k++) begin
            step();
            if (rand_bp) res_ready = ($urandom_range(0, 2) != 0);
            if (got_q.size() >= target) break;
        end
        res_ready = 1'b1;
        check("run_complete", 64'(got_q.size()), 64'(target));
    endtask

    task automatic check_results();
        while (got_seen < got_q.size()) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 64'(got_q[got_seen]), 64'h0);
            end else begin
                check("result", 64'(got_q[got_seen]), 64'(exp_q.pop_front()));
            end
            got_seen++;
        end
        check("missing_results", 64'(exp_q.size()), 64'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        req_valid = '0;
        res_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst   = 1'b0;
        m_ptr = 0;
        exp_q.delete();
        tick();
        acc_seen = acc_id_q.size();
        got_seen = got_q.size();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [M+N-1:0]  held_p;
        logic [ID_W-1:0] held_id;
        logic [NREQ-1:0] mask;
        int bad, n, g0, target;

        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b1;
        repeat (3) tick();

        // Reset state, with every requester valid to show req_ready stays low under reset.
        req_valid = '1;
        #1;
        check("rst_req_ready", 64'(req_ready), 64'h0);
        check("rst_mul_en", 64'(mul_en), 64'h0);
        check("rst_res_valid", 64'(res_valid), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_res_id", 64'(res_id), 64'h0);
        check("rst_res_product", 64'(res_product), 64'h0);
        check("rst_mul_ops", 64'({mul_a, mul_b}), 64'h0);
        do_reset();

        // Single request from requester 0.
        n = en_cyc;
        bad = rdy_cyc;
        set_req(0, 26'h0050A01, 14'h3024);
        issue(4'b0001);
        run(1, 1'b0, 200);
        check("single_ready_cycles", 64'(rdy_cyc - bad), 64'd1);
        check("single_en_cycles", 64'(en_cyc - n), 64'(MUL_LAT));
        // res_valid first seen one edge after the edge that set it.
        check("single_latency", 64'(rise_cyc_q[$] - acc_cyc_q[$] - 1), 64'(MUL_LAT));
        check("single_product", 64'(got_q[$]), 64'({2'd0, 40'h00F2959824}));
        check_results();

        // All four valid together.
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, M'(i + 1), N'(3));
        issue(4'b1111);
        run(4, 1'b0, 400);
        n = acc_id_q.size();
        for (int i = 0; i < 4; i++) begin
            check("all4_order", 64'(acc_id_q[n-4+i]), 64'(i));
            check("all4_product", 64'(got_q[got_q.size()-4+i] & {(M+N){1'b1}}), 64'(3 * (i + 1)));
        end
        for (int i = 1; i < 4; i++) begin
            check("all4_spacing", 64'(acc_cyc_q[n-4+i] - acc_cyc_q[n-5+i]), 64'(MUL_LAT + 2));
        end
        check_results();

        // Backpressure: result held for 10 cycles with requester 1 still waiting.
        res_ready = 1'b0;
        set_req(0, M'($urandom()), N'($urandom()));
        set_req(1, M'($urandom()), N'($urandom()));
        issue(4'b0011);
        for (int k = 0; k < 100; k++) begin
            if (res_valid) break;
            step();
        end
        check("bp_valid", 64'(res_valid), 64'h1);
        held_p  = res_product;
        held_id = res_id;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (res_valid !== 1'b1 || res_product !== held_p || res_id !== held_id ||
                busy !== 1'b1 || req_ready !== '0) bad++;
        end
        check("bp_hold", 64'(bad), 64'h0);
        res_ready = 1'b1;
        step();
        check("bp_idle", 64'(busy), 64'h0);
        check("bp_next_grant", 64'(req_ready), 64'b0010);
        run(1, 1'b0, 200);
        check_results();

        // Pointer wrap: move pointer to 3, then requesters 1 and 3.
        set_req(2, M'($urandom()), N'($urandom()));
        issue(4'b0100);
        run(1, 1'b0, 200);
        set_req(1, M'($urandom()), N'($urandom()));
        set_req(3, M'($urandom()), N'($urandom()));
        issue(4'b1010);
        run(2, 1'b0, 200);
        check("wrap_first", 64'(acc_id_q[acc_id_q.size()-2]), 64'd3);
        check("wrap_second", 64'(acc_id_q[$]), 64'd1);
        check_results();

        // Asynchronous reset while BUSY with the counter at 5.
        do_reset();
        target = acc_seen + 1;
        set_req(0, M'($urandom()), N'($urandom()));
        for (int k = 0; k < 50; k++) begin
            step();
            if (acc_seen >= target) break;
        end
        check("abort_accepted", 64'(acc_seen), 64'(target));
        repeat (5) step();
        set_req(2, M'($urandom()), N'($urandom()));
        g0 = got_q.size();
        #2;
        rst = 1'b1;
        #1;
        check("abort_mul_en", 64'(mul_en), 64'h0);
        check("abort_res_valid", 64'(res_valid), 64'h0);
        check("abort_busy", 64'(busy), 64'h0);
        check("abort_req_ready", 64'(req_ready), 64'h0);
        @(negedge clk);
        @(negedge clk);
        rst   = 1'b0;
        m_ptr = 0;
        issue(4'b0100);
        run(1, 1'b0, 200);
        check("abort_regrant_id", 64'(acc_id_q[$]), 64'd2);
        check("abort_one_result", 64'(got_q.size() - g0), 64'd1);
        check_results();

        // Largest operands.
        set_req(3, {M{1'b1}}, {N{1'b1}});
        issue(4'b1000);
        run(1, 1'b0, 200);
        check("edge_product", 64'(got_q[$] & {(M+N){1'b1}}), 64'h00FFFBFFC001);
        check_results();

        // Random masks, operands and result backpressure.
        for (int r = 0; r < 12; r++) begin
            mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            n = 0;
            for (int i = 0; i < NREQ; i++) begin
                if (mask[i]) begin
                    set_req(i, M'($urandom()), N'($urandom()));
                    n++;
                end
            end
            issue(mask);
            run(n, 1'b1, 200 * n);
            check_results();
        end

        check("ready_onehot", 64'(onehot_bad), 64'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
